instr_fetch: RTL and testbench

//  Fetch stage directly upstream of the control decoder: owns the program counter, drives a

---
 rtl/instr_fetch.sv | 152 +++++++++++++++
 tb/tb_instr_fetch.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Fetch stage: owns the program counter, addresses a synchronous instruction ROM
// and hands one registered instruction per cycle (with valid and address) to the
// decoder. Stall holds the whole fetch pipe. A jump redirects the PC and flushes
// everything in flight. Start/done sequence a program from address 0 up to
// PROG_LEN-1.
//
// Pipe: F = {f_pc, f_valid} is the address the ROM is reading this cycle. D is the
// output register. While stalled, the ROM is re-addressed with f_pc, so the read
// data matches F again when the stall releases.
module instr_fetch #(
    parameter int PC_W     = 10,
    parameter int PROG_LEN = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stall,
    input  logic            jump_en,
    input  logic [PC_W-1:0] jump_target,
    output logic [PC_W-1:0] imem_addr,
    input  logic [8:0]      imem_rdata,
    output logic [8:0]      mach_code,
    output logic            inst_valid,
    output logic [PC_W-1:0] inst_pc,
    output logic            done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Last address of the program, and the program length widened by one bit so
    // that a length of exactly 2**PC_W can still be compared against.
    localparam logic [PC_W-1:0] LAST_PC     = PC_W'(PROG_LEN - 1);
    localparam logic [PC_W:0]   PROG_LEN_EX = (PC_W + 1)'(PROG_LEN);

    state_t          state_q,      state_d;
    logic [PC_W-1:0] pc_q,         pc_d;
    logic [PC_W-1:0] f_pc_q,       f_pc_d;
    logic            f_valid_q,    f_valid_d;
    logic [8:0]      mach_code_q,  mach_code_d;
    logic [PC_W-1:0] inst_pc_q,    inst_pc_d;
    logic            inst_valid_q, inst_valid_d;
    logic            done_q,       done_d;

    logic            issuing_s;
    logic            jump_oob_s;

    assign issuing_s  = (state_q == S_RUN);
    assign jump_oob_s = ({1'b0, jump_target} >= PROG_LEN_EX);

    // The ROM address is combinational. While stalled, re-read the address that is
    // already in F so the data seen after the stall still belongs to f_pc.
    assign imem_addr  = stall ? f_pc_q : pc_q;

    assign mach_code  = mach_code_q;
    assign inst_valid = inst_valid_q;
    assign inst_pc    = inst_pc_q;
    assign done       = done_q;

    // Next-state logic: program sequencing, jump/flush, stall hold, and pipe advance.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        f_pc_d       = f_pc_q;
        f_valid_d    = f_valid_q;
        mach_code_d  = mach_code_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        done_d       = done_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // Start always beats a jump here. Stall and jump are ignored.
                if (start) begin
                    pc_d    = '0;
                    done_d  = 1'b0;
                    state_d = S_RUN;
                end else begin
                    state_d = state_q;
                end
            end

            S_RUN, S_DRAIN: begin
                if (jump_en) begin
                    // A jump takes priority over stall. It flushes both pipe entries.
                    f_valid_d    = 1'b0;
                    inst_valid_d = 1'b0;
                    if (jump_oob_s) begin
                        state_d = S_DRAIN;
                    end else begin
                        pc_d    = jump_target;
                        state_d = S_RUN;
                    end
                end else if (!stall) begin
                    mach_code_d  = imem_rdata;
                    inst_pc_d    = f_pc_q;
                    inst_valid_d = f_valid_q;
                    f_pc_d       = pc_q;
                    f_valid_d    = issuing_s;
                    if (issuing_s) begin
                        // Issue the last address but keep pc on it. The pc never wraps.
                        if (pc_q == LAST_PC) begin
                            state_d = S_DRAIN;
                        end else begin
                            pc_d = pc_q + PC_W'(1);
                        end
                    end else if (!f_valid_q) begin
                        // Nothing is left in F, and D is being emptied on this edge.
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and pipe registers. Asynchronous reset clears everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            f_pc_q       <= '0;
            f_valid_q    <= 1'b0;
            mach_code_q  <= 9'd0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            f_pc_q       <= f_pc_d;
            f_valid_q    <= f_valid_d;
            mach_code_q  <= mach_code_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch. There are two instances: dut0 uses PROG_LEN=1024 and
// dut1 uses PROG_LEN=16. Directed scenarios check fixed expectations. A random
// phase compares both instances against a behavioural model: a two-deep queue of
// in-flight addresses plus a "fetching" flag.
module tb_instr_fetch;

    localparam int PL0 = 1024;
    localparam int PL1 = 16;

    typedef struct {
        bit active;    // program started and not yet finished
        bit fetching;  // addresses are still being issued
        bit fin;       // done level
        int next_pc;   // next address to issue
        int f_pc;      // address currently being read
        bit f_v;
        bit o_v;       // presented instruction
        int o_pc;
        int o_code;
    } model_t;

    logic       clk;
    logic       rst_n;
    logic       start_s       [2];
    logic       stall_s       [2];
    logic       jump_en_s     [2];
    logic [9:0] jump_target_s [2];
    logic [9:0] imem_addr_s   [2];
    logic [8:0] imem_rdata_s  [2];
    logic [8:0] mach_code_s   [2];
    logic       inst_valid_s  [2];
    logic [9:0] inst_pc_s     [2];
    logic       done_s        [2];
    logic [8:0] rom0 [1024];
    logic [8:0] rom1 [1024];

    model_t m0, m1;
    int total;
    int bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    instr_fetch #(.PC_W(10), .PROG_LEN(PL0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .stall(stall_s[0]),
        .jump_en(jump_en_s[0]), .jump_target(jump_target_s[0]), .imem_addr(imem_addr_s[0]),
        .imem_rdata(imem_rdata_s[0]), .mach_code(mach_code_s[0]), .inst_valid(inst_valid_s[0]),
        .inst_pc(inst_pc_s[0]), .done(done_s[0])
    );

    instr_fetch #(.PC_W(10), .PROG_LEN(PL1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .stall(stall_s[1]),
        .jump_en(jump_en_s[1]), .jump_target(jump_target_s[1]), .imem_addr(imem_addr_s[1]),
        .imem_rdata(imem_rdata_s[1]), .mach_code(mach_code_s[1]), .inst_valid(inst_valid_s[1]),
        .inst_pc(inst_pc_s[1]), .done(done_s[1])
    );

    // Synchronous ROMs: data appears one cycle after the address.
    always @(posedge clk) begin
        imem_rdata_s[0] <= rom0[imem_addr_s[0]];
        imem_rdata_s[1] <= rom1[imem_addr_s[1]];
    end

    // Behavioural model for one clock edge, given the inputs seen at that edge.
    function automatic model_t step(input model_t mi, input bit st, input bit sl, input bit je,
                                    input int jt, input int plen, input int code);
        model_t r;
        r = mi;
        if (!r.active) begin
            if (st) begin
                r.active   = 1'b1;
                r.fetching = 1'b1;
                r.next_pc  = 0;
                r.fin      = 1'b0;
            end
            return r;
        end
        if (je) begin
            r.f_v = 1'b0;
            r.o_v = 1'b0;
            if (jt < plen) begin
                r.next_pc  = jt;
                r.fetching = 1'b1;
            end else begin
                r.fetching = 1'b0;
            end
            return r;
        end
        if (sl) return r;
        if (!r.fetching && !r.f_v) begin
            r.fin    = 1'b1;
            r.active = 1'b0;
        end
        r.o_v    = r.f_v;
        r.o_pc   = r.f_pc;
        r.o_code = code;
        r.f_pc   = r.next_pc;
        r.f_v    = r.fetching;
        if (r.fetching) begin
            if (r.next_pc == plen - 1) r.fetching = 1'b0;
            else r.next_pc = r.next_pc + 1;
        end
        return r;
    endfunction

    task automatic drive(input bit u, input bit st, input bit sl, input bit je, input int jt);
        start_s[u]       = st;
        stall_s[u]       = sl;
        jump_en_s[u]     = je;
        jump_target_s[u] = 10'(jt);
    endtask

    task automatic clear_in();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
    endtask

    // Advance one clock: step both models with the current inputs, and return at the negedge.
    task automatic tick();
        model_t n0, n1;
        n0 = step(m0, start_s[0], stall_s[0], jump_en_s[0], int'(jump_target_s[0]), PL0,
                  int'(rom0[10'(m0.f_pc)]));
        n1 = step(m1, start_s[1], stall_s[1], jump_en_s[1], int'(jump_target_s[1]), PL1,
                  int'(rom1[10'(m1.f_pc)]));
        @(posedge clk);
        m0 = n0;
        m1 = n1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        clear_in();
        #3 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            total++; if (inst_valid_s[i[0]] !== 1'b0) begin bad++; $display("FAIL reset_valid u%0d got %0d want 0", i, inst_valid_s[i[0]]); end
            total++; if (done_s[i[0]] !== 1'b0) begin bad++; $display("FAIL reset_done u%0d got %0d want 0", i, done_s[i[0]]); end
            total++; if (inst_pc_s[i[0]] !== 10'd0) begin bad++; $display("FAIL reset_pc u%0d got %0d want 0", i, inst_pc_s[i[0]]); end
            total++; if (mach_code_s[i[0]] !== 9'd0) begin bad++; $display("FAIL reset_code u%0d got %0d want 0", i, mach_code_s[i[0]]); end
            total++; if (imem_addr_s[i[0]] !== 10'd0) begin bad++; $display("FAIL reset_addr u%0d got %0d want 0", i, imem_addr_s[i[0]]); end
        end
        m0 = '{default: 0};
        m1 = '{default: 0};
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0);
        tick();
        clear_in();
        total++; if (inst_valid_s[0] !== 1'b0) begin bad++; $display("FAIL stream_first got %0d want 0", inst_valid_s[0]); end
        for (int k = 1; k <= 7; k++) begin
            tick();
            total++; if (inst_valid_s[0] !== (k >= 2)) begin bad++; $display("FAIL stream_valid k%0d got %0d want %0d", k, inst_valid_s[0], k >= 2); end
            if (k >= 2) begin
                total++; if (inst_pc_s[0] !== 10'(k - 2)) begin bad++; $display("FAIL stream_pc k%0d got %0d want %0d", k, inst_pc_s[0], k - 2); end
                total++; if (mach_code_s[0] !== 9'(k - 2)) begin bad++; $display("FAIL stream_code k%0d got %0d want %0d", k, mach_code_s[0], k - 2); end
            end
        end
        total++; if (done_s[0] !== 1'b0) begin bad++; $display("FAIL stream_done got %0d want 0", done_s[0]); end
    endtask

    task automatic test_stall();
        #1;
        total++; if (imem_addr_s[0] !== 10'd7) begin bad++; $display("FAIL stall_addr_run got %0d want 7", imem_addr_s[0]); end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 0);
        #1;
        total++; if (imem_addr_s[0] !== 10'd6) begin bad++; $display("FAIL stall_addr_hold got %0d want 6", imem_addr_s[0]); end
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (inst_valid_s[0] !== 1'b1) begin bad++; $display("FAIL stall_valid c%0d got %0d want 1", k, inst_valid_s[0]); end
            total++; if (inst_pc_s[0] !== 10'd5) begin bad++; $display("FAIL stall_pc c%0d got %0d want 5", k, inst_pc_s[0]); end
            total++; if (mach_code_s[0] !== 9'd5) begin bad++; $display("FAIL stall_code c%0d got %0d want 5", k, mach_code_s[0]); end
        end
        clear_in();
        for (int k = 6; k <= 7; k++) begin
            tick();
            total++; if (inst_pc_s[0] !== 10'(k) || inst_valid_s[0] !== 1'b1) begin bad++; $display("FAIL stall_resume got pc %0d v %0d want pc %0d v 1", inst_pc_s[0], inst_valid_s[0], k); end
        end
    endtask

    task automatic test_jump();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32);
        tick();
        clear_in();
        total++; if (inst_valid_s[0] !== 1'b0) begin bad++; $display("FAIL jump_flush1 got %0d want 0", inst_valid_s[0]); end
        tick();
        total++; if (inst_valid_s[0] !== 1'b0) begin bad++; $display("FAIL jump_flush2 got %0d want 0", inst_valid_s[0]); end
        for (int k = 32; k <= 33; k++) begin
            tick();
            total++; if (inst_pc_s[0] !== 10'(k) || inst_valid_s[0] !== 1'b1) begin bad++; $display("FAIL jump_target got pc %0d v %0d want pc %0d v 1", inst_pc_s[0], inst_valid_s[0], k); end
            total++; if (mach_code_s[0] !== 9'(k)) begin bad++; $display("FAIL jump_code got %0d want %0d", mach_code_s[0], k); end
        end
    endtask

    task automatic test_end_of_program();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 0);
        tick();
        clear_in();
        for (int k = 1; k <= 18; k++) begin
            tick();
            total++; if (inst_valid_s[1] !== (k >= 2 && k <= 17)) begin bad++; $display("FAIL end_valid k%0d got %0d want %0d", k, inst_valid_s[1], k >= 2 && k <= 17); end
            total++; if (done_s[1] !== (k == 18)) begin bad++; $display("FAIL end_done k%0d got %0d want %0d", k, done_s[1], k == 18); end
            if (k >= 2 && k <= 17) begin
                total++; if (inst_pc_s[1] !== 10'(k - 2)) begin bad++; $display("FAIL end_pc k%0d got %0d want %0d", k, inst_pc_s[1], k - 2); end
                total++; if (mach_code_s[1] !== rom1[10'(k - 2)]) begin bad++; $display("FAIL end_code k%0d got %0d want %0d", k, mach_code_s[1], rom1[10'(k - 2)]); end
            end
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3);
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (inst_valid_s[1] !== 1'b0 || done_s[1] !== 1'b1) begin bad++; $display("FAIL done_jump c%0d got v %0d d %0d want v 0 d 1", k, inst_valid_s[1], done_s[1]); end
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1, 5);
        tick();
        clear_in();
        total++; if (done_s[1] !== 1'b0) begin bad++; $display("FAIL restart_done got %0d want 0", done_s[1]); end
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k >= 2) begin
                total++; if (inst_pc_s[1] !== 10'(k - 2) || inst_valid_s[1] !== 1'b1) begin bad++; $display("FAIL restart_pc got pc %0d v %0d want pc %0d v 1", inst_pc_s[1], inst_valid_s[1], k - 2); end
            end
        end
    endtask

    task automatic test_jump_stall();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 16);
        tick();
        clear_in();
        total++; if (inst_valid_s[1] !== 1'b0 || done_s[1] !== 1'b0) begin bad++; $display("FAIL oob_jump got v %0d d %0d want v 0 d 0", inst_valid_s[1], done_s[1]); end
        tick();
        total++; if (inst_valid_s[1] !== 1'b0 || done_s[1] !== 1'b1) begin bad++; $display("FAIL oob_done got v %0d d %0d want v 0 d 1", inst_valid_s[1], done_s[1]); end
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1022);
        tick();
        clear_in();
        total++; if (inst_valid_s[0] !== 1'b0) begin bad++; $display("FAIL js_flush got %0d want 0", inst_valid_s[0]); end
        for (int k = 1; k <= 4; k++) begin
            tick();
            total++; if (inst_valid_s[0] !== (k == 2 || k == 3)) begin bad++; $display("FAIL js_valid k%0d got %0d want %0d", k, inst_valid_s[0], k == 2 || k == 3); end
            total++; if (done_s[0] !== (k == 4)) begin bad++; $display("FAIL js_done k%0d got %0d want %0d", k, done_s[0], k == 4); end
            if (k == 2 || k == 3) begin
                total++; if (inst_pc_s[0] !== 10'(1020 + k)) begin bad++; $display("FAIL js_pc k%0d got %0d want %0d", k, inst_pc_s[0], 1020 + k); end
            end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0);
        tick();
        clear_in();
        for (int k = 0; k < 5; k++) tick();
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            total++; if (inst_valid_s[i[0]] !== 1'b0 || done_s[i[0]] !== 1'b0) begin bad++; $display("FAIL arst_flags u%0d got v %0d d %0d want 0 0", i, inst_valid_s[i[0]], done_s[i[0]]); end
            total++; if (inst_pc_s[i[0]] !== 10'd0 || mach_code_s[i[0]] !== 9'd0) begin bad++; $display("FAIL arst_data u%0d got pc %0d code %0d want 0 0", i, inst_pc_s[i[0]], mach_code_s[i[0]]); end
            total++; if (imem_addr_s[i[0]] !== 10'd0) begin bad++; $display("FAIL arst_addr u%0d got %0d want 0", i, imem_addr_s[i[0]]); end
        end
        m0 = '{default: 0};
        m1 = '{default: 0};
        for (int i = 0; i < 1024; i++) begin
            rom0[i] = 9'($urandom);
            rom1[i] = 9'($urandom);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 5);
        for (int k = 0; k < 4; k++) begin
            tick();
            total++; if (inst_valid_s[0] !== 1'b0 || done_s[0] !== 1'b0) begin bad++; $display("FAIL idle_hold c%0d got v %0d d %0d want 0 0", k, inst_valid_s[0], done_s[0]); end
            total++; if (imem_addr_s[0] !== 10'd0) begin bad++; $display("FAIL idle_addr c%0d got %0d want 0", k, imem_addr_s[0]); end
        end
        clear_in();
    endtask

    task automatic test_random();
        model_t mm;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 0);
        tick();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                drive(i[0], $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 25,
                      $urandom_range(0, 99) < 5,
                      (i == 1) ? int'($urandom_range(0, 19)) :
                      (($urandom_range(0, 3) == 0) ? int'($urandom_range(1000, 1023)) : int'($urandom_range(0, 1023))));
            end
            #1;
            for (int i = 0; i < 2; i++) begin
                mm = (i == 0) ? m0 : m1;
                total++; if (imem_addr_s[i[0]] !== 10'(stall_s[i[0]] ? mm.f_pc : mm.next_pc)) begin bad++; $display("FAIL rnd_addr u%0d c%0d got %0d want %0d", i, c, imem_addr_s[i[0]], stall_s[i[0]] ? mm.f_pc : mm.next_pc); end
            end
            tick();
            for (int i = 0; i < 2; i++) begin
                mm = (i == 0) ? m0 : m1;
                total++; if (inst_valid_s[i[0]] !== mm.o_v) begin bad++; $display("FAIL rnd_valid u%0d c%0d got %0d want %0d", i, c, inst_valid_s[i[0]], mm.o_v); end
                total++; if (done_s[i[0]] !== mm.fin) begin bad++; $display("FAIL rnd_done u%0d c%0d got %0d want %0d", i, c, done_s[i[0]], mm.fin); end
                if (mm.o_v) begin
                    total++; if (inst_pc_s[i[0]] !== 10'(mm.o_pc)) begin bad++; $display("FAIL rnd_pc u%0d c%0d got %0d want %0d", i, c, inst_pc_s[i[0]], mm.o_pc); end
                    total++; if (mach_code_s[i[0]] !== 9'(mm.o_code)) begin bad++; $display("FAIL rnd_code u%0d c%0d got %0d want %0d", i, c, mach_code_s[i[0]], mm.o_code); end
                end
            end
        end
        clear_in();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 1024; i++) begin
            rom0[i] = 9'(i);
            rom1[i] = 9'(i * 7 + 3);
        end
        test_reset();
        test_stream();
        test_stall();
        test_jump();
        test_end_of_program();
        test_jump_stall();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
